bist_response_analyzer: RTL

//  - Receiving end of the BIST controller control bus (init/running/toggle/finish).
//  - Generates LFSR test vectors for the circuit under test (CUT) and compacts CUT responses into a MISR.
//  - Counts running cycles and toggle pulses.
//  - On finish, compares the signature and run length against golden values and reports pass/fail.

---
 rtl/bist_response_analyzer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bist_response_analyzer.sv
// +------------------------------------------------------------------------+
// | bist_response_analyzer : LFSR pattern source, MISR compactor, cycle/   |
// | toggle counters and golden-value evaluation for a BIST session.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module bist_response_analyzer #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = 8'h1D,
  parameter logic [WIDTH-1:0] SEED       = 8'h01,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = 8'h00,
  parameter int               NCLOCK     = 650,
  parameter int               NTOGGLE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             toggle,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_resp,
  output logic [WIDTH-1:0] test_vector,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  localparam int CW = $clog2(NCLOCK + 1) + 1;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ARMED = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_CHECK = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [CW-1:0] c_CYC_MAX = '1;
  localparam logic [CW-1:0] c_NCLOCK  = CW'(NCLOCK);
  localparam logic [15:0]   c_TOG_MAX = 16'hFFFF;
  localparam logic [15:0]   c_NTOGGLE = 16'(NTOGGLE);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nx;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_misr;
  logic [CW-1:0]    r_cyc_cnt;
  logic [15:0]      r_tog_cnt;
  logic             r_tog_d;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;

  logic             w_active;
  logic             w_shift;
  logic             w_tog_inc;
  logic             w_eval;
  logic             w_match;
  logic [WIDTH-1:0] w_lfsr_nx;
  logic [WIDTH-1:0] w_misr_nx;

  // Galois shift: multiply by x modulo the feedback polynomial
  assign w_lfsr_nx = {r_lfsr[WIDTH-2:0], 1'b0} ^ (r_lfsr[WIDTH-1] ? POLY : '0);
  assign w_misr_nx = {r_misr[WIDTH-2:0], 1'b0} ^ (r_misr[WIDTH-1] ? POLY : '0) ^ cut_resp;

  assign w_match = (r_misr == GOLDEN_SIG) && (r_cyc_cnt == c_NCLOCK) &&
                   ((NTOGGLE == 0) || (r_tog_cnt == c_NTOGGLE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    if (init) begin
      w_state_nx = c_ARMED;
    end else begin
      case (r_state)
        c_IDLE:  w_state_nx = c_IDLE;
        c_ARMED: w_state_nx = finish ? c_CHECK : (running ? c_RUN : c_ARMED);
        c_RUN:   w_state_nx = finish ? c_CHECK : c_RUN;
        c_CHECK: w_state_nx = c_DONE;
        c_DONE:  w_state_nx = c_DONE;
        default: w_state_nx = c_IDLE;
      endcase
    end
  end

  // ARMED and RUN share the same datapath behaviour; init overrides everything
  always_comb begin
    w_active  = !init && ((r_state == c_ARMED) || (r_state == c_RUN));
    w_shift   = w_active && running;
    w_tog_inc = w_active && toggle && !r_tog_d;
    w_eval    = !init && (r_state == c_CHECK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr    <= SEED;
      r_misr    <= '0;
      r_cyc_cnt <= '0;
      r_tog_cnt <= '0;
      r_tog_d   <= 1'b0;
    end else begin
      r_tog_d <= toggle;
      if (init) begin
        r_lfsr    <= SEED;
        r_misr    <= '0;
        r_cyc_cnt <= '0;
        r_tog_cnt <= '0;
      end else begin
        if (w_shift) begin
          r_lfsr <= w_lfsr_nx;
          r_misr <= w_misr_nx;
          if (r_cyc_cnt != c_CYC_MAX) begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
          end
        end
        if (w_tog_inc && (r_tog_cnt != c_TOG_MAX)) begin
          r_tog_cnt <= r_tog_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (init) begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (w_eval) begin
      r_done <= 1'b1;
      r_pass <= w_match;
      r_fail <= !w_match;
    end
  end

  assign test_vector = r_lfsr;
  assign signature   = r_misr;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;

endmodule

`default_nettype wire
